// File: rtl/alu_mul_sequencer_if.sv
// Handshake and ALU-drive bundle for the shift-and-add multiplier sequencer.
// The slave side is the sequencer; the master side issues requests and hosts the ALU.
interface alu_mul_sequencer_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         busy;
  logic         done;
  logic [63:0]  product;
  logic [63:0]  alu_a;
  logic [63:0]  alu_b;
  logic [4:0]   alu_fs;
  logic         alu_cin;
  logic [63:0]  alu_f;

  modport master (
    output start, op_a, op_b, alu_f,
    input  busy, done, product, alu_a, alu_b, alu_fs, alu_cin
  );

  modport slave (
    input  start, op_a, op_b, alu_f,
    output busy, done, product, alu_a, alu_b, alu_fs, alu_cin
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned N x N multiplier that borrows the shared 64-bit ALU, alternating
// ADD and shift-left micro-steps; no multiplier hardware of its own.
module alu_mul_sequencer #(
  parameter int N          = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic               clock,
  input logic               reset,
  alu_mul_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_SHL  = 5'b10100;
  localparam logic [4:0] FS_ZERO = 5'b11000;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [63:0]      product_q, product_d;

  logic [63:0]      alu_a, alu_b;
  logic [4:0]       alu_fs;
  logic             alu_cin;
  logic [N-1:0]     mplier_shr;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    product_d  = product_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_fs     = FS_ZERO;
    alu_cin    = 1'b0;
    mplier_shr = mplier_q >> 1;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = 64'(bus.op_a);
          mplier_d = bus.op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        // The ALU always computes acc+mcand; only the commit depends on the multiplier bit.
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_fs = FS_ADD;
        if (mplier_q[0]) acc_d = bus.alu_f;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_a    = mcand_q;
        alu_fs   = FS_SHL;
        mcand_d  = bus.alu_f;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
        // done and product are loaded together here so they are valid in the same cycle.
        if (cnt_q == CNT_LAST || (EARLY_EXIT && mplier_shr == '0)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          product_d = acc_q;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_fs  = alu_fs;
  assign bus.alu_cin = alu_cin;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one instance with early exit, one without,
// each paired with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        sel0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [4:0] fs, input logic cin);
    case (fs)
      5'b01000: alu_model = a + b + 64'(cin);
      5'b10100: alu_model = a << 1;
      5'b11000: alu_model = 64'd0;
      default:  alu_model = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  alu_mul_sequencer_if #(.N(32)) if0 ();
  alu_mul_sequencer_if #(.N(32)) if1 ();

  assign if0.start = start & sel0;
  assign if0.op_a  = op_a;
  assign if0.op_b  = op_b;
  assign if0.alu_f = alu_model(if0.alu_a, if0.alu_b, if0.alu_fs, if0.alu_cin);
  assign if1.start = start & ~sel0;
  assign if1.op_a  = op_a;
  assign if1.op_b  = op_b;
  assign if1.alu_f = alu_model(if1.alu_a, if1.alu_b, if1.alu_fs, if1.alu_cin);

  alu_mul_sequencer #(.N(32), .EARLY_EXIT(1'b0)) dut0 (.clock(clk), .reset(reset), .bus(if0));
  alu_mul_sequencer #(.N(32), .EARLY_EXIT(1'b1)) dut1 (.clock(clk), .reset(reset), .bus(if1));

  logic        busy, done;
  logic [63:0] product, alu_a;
  logic [4:0]  alu_fs;
  assign busy    = sel0 ? if0.busy    : if1.busy;
  assign done    = sel0 ? if0.done    : if1.done;
  assign product = sel0 ? if0.product : if1.product;
  assign alu_a   = sel0 ? if0.alu_a   : if1.alu_a;
  assign alu_fs  = sel0 ? if0.alu_fs  : if1.alu_fs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat);
    int lat;
    bit fs_ok;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0; fs_ok = 1'b1;
    chk({tag, "_busy_rise"}, busy, 1);
    while (!done && lat < 200) begin
      if (alu_fs != ((lat % 2 == 0) ? 5'b01000 : 5'b10100)) fs_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_fs_alternate"}, fs_ok, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_fs_park"}, alu_fs, 5'b11000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    bit saw_done;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sel0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_fs", alu_fs, 5'b11000);
    chk("rst_alu_a", alu_a, 0);

    run_op("t13x6", 32'd13, 32'd6, 64'd78, 6);
    run_op("tmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64);
    run_op("tzero_ee1", 32'h1234, 32'd0, 64'd0, 2);
    sel0 = 1'b1;
    run_op("tzero_ee0", 32'h1234, 32'd0, 64'd0, 64);
    run_op("t5x7_ee0", 32'd5, 32'd7, 64'd35, 64);
    sel0 = 1'b0;

    // Second request while busy must be dropped.
    @(negedge clk);
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 0;
    @(negedge clk);
    lat++; op_a = 32'd7; op_b = 32'd7; start = 1'b1;
    @(negedge clk);
    lat++; start = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ign_latency", lat, 6);
    chk("busy_ign_product", product, 15);
    @(negedge clk);
    chk("busy_ign_idle1", busy, 0);
    @(negedge clk);
    chk("busy_ign_not_queued", busy, 0);

    // Mid-operation reset aborts without done.
    @(negedge clk);
    op_a = 32'hABCD; op_b = 32'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_product", product, 0);
    chk("abort_fs", alu_fs, 5'b11000);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    // start held high: back-to-back runs with one idle cycle between.
    @(negedge clk);
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("held_first_latency", lat, 4);
    chk("held_first_product", product, 6);
    @(negedge clk);
    chk("held_gap_busy", busy, 0);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    lat = 2;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("held_period", lat, 6);
    chk("held_second_product", product, 6);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_stop_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
